grid_cursor: RTL and testbench

GRID_CURSOR -- requirements
Module: grid_cursor

---
 rtl/grid_cursor.sv | 223 ++++++++++++++++++++++
 tb/tb_grid_cursor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_cursor.sv
// grid_cursor: keyboard-style cursor over a ROWS x COLS board.
//
// A direction request steps the cursor once immediately. If the request is
// held for HOLD_CYC cycles it steps again, and after that it steps every
// REPEAT_CYC cycles. The cursor moves only while en is high.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous reset, active low
//   en             movement enable (low while the matcher is busy)
//   up/down/left/right  debounced, level-held direction requests
//   cur_bus        one-hot cursor position, bit = row*COLS+col
//   row, col       registered cursor coordinates
//   move           one-cycle pulse when the position changes
//
// Configuration
//   GRID_CURSOR_WRAP_EN  defined: a step past an edge wraps to the opposite
//                        edge. Undefined (default): the step is blocked.
//
// FSM states
//   state    | meaning
//   S_IDLE   | no qualified request; the next request steps at once
//   S_HOLD   | direction held; waiting HOLD_CYC cycles before auto-repeat
//   S_REPEAT | auto-repeat; steps every REPEAT_CYC cycles

module grid_cursor #(
  parameter int ROWS       = 6,
  parameter int COLS       = 6,
  parameter int HOLD_CYC   = 25000000,
  parameter int REPEAT_CYC = 10000000,
  parameter int START_ROW  = 0,
  parameter int START_COL  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      up,
  input  logic                      down,
  input  logic                      left,
  input  logic                      right,
  output logic [ROWS*COLS-1:0]      cur_bus,
  output logic [$clog2(ROWS)-1:0]   row,
  output logic [$clog2(COLS)-1:0]   col,
  output logic                      move
);

  localparam int RW      = $clog2(ROWS);
  localparam int CLW     = $clog2(COLS);
  localparam int NCELL   = ROWS * COLS;
  localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

`ifdef GRID_CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [RW-1:0]    ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CLW-1:0]   COL_LAST  = CLW'(COLS - 1);
  localparam logic [RW-1:0]    ROW_START = RW'(START_ROW);
  localparam logic [CLW-1:0]   COL_START = CLW'(START_COL);
  localparam logic [NCELL-1:0] BUS_START = NCELL'(1) << (START_ROW * COLS + START_COL);
  localparam logic [CNTW-1:0]  HOLD_LAST = CNTW'(HOLD_CYC - 1);
  localparam logic [CNTW-1:0]  REP_LAST  = CNTW'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    D_UP    = 2'd0,
    D_DOWN  = 2'd1,
    D_LEFT  = 2'd2,
    D_RIGHT = 2'd3
  } dir_t;

  state_t            state_q, state_d;
  dir_t              dir_q, dir_d;
  dir_t              req_dir;
  logic              any_req;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              step;

  logic [RW-1:0]     row_d;
  logic [CLW-1:0]    col_d;
  logic [NCELL-1:0]  cur_bus_d;
  logic              move_d;

  // Fixed priority: up > down > left > right.
  always_comb begin
    any_req = up | down | left | right;
    req_dir = D_RIGHT;
    if (up)
      req_dir = D_UP;
    else if (down)
      req_dir = D_DOWN;
    else if (left)
      req_dir = D_LEFT;
  end

  // State register plus the registered datapath it drives.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dir_q   <= D_UP;
      cnt_q   <= '0;
      row     <= ROW_START;
      col     <= COL_START;
      cur_bus <= BUS_START;
      move    <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      row     <= row_d;
      col     <= col_d;
      cur_bus <= cur_bus_d;
      move    <= move_d;
    end
  end

  // Next-state logic: decides when a step happens and tracks hold timing.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    if (!en || !any_req) begin
      // Dropping en or releasing all keys forgets the press entirely, so a
      // key still held when en returns behaves like a fresh press.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          step    = 1'b1;
          dir_d   = req_dir;
          cnt_d   = '0;
          state_d = S_HOLD;
        end
        S_HOLD: begin
          if (req_dir != dir_q) begin
            step    = 1'b1;
            dir_d   = req_dir;
            cnt_d   = '0;
            state_d = S_HOLD;
          end else if (cnt_q == HOLD_LAST) begin
            step    = 1'b1;
            cnt_d   = '0;
            state_d = S_REPEAT;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        S_REPEAT: begin
          if (req_dir != dir_q) begin
            step    = 1'b1;
            dir_d   = req_dir;
            cnt_d   = '0;
            state_d = S_HOLD;
          end else if (cnt_q == REP_LAST) begin
            step  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic: applies a step to the position, handling board edges.
  // The stepping direction is always req_dir: on a repeat step it equals
  // the latched direction, on any other step it is the one being latched.
  always_comb begin
    row_d = row;
    col_d = col;
    if (step) begin
      case (req_dir)
        D_UP: begin
          if (row != '0)
            row_d = row - RW'(1);
          else if (WRAP)
            row_d = ROW_LAST;
        end
        D_DOWN: begin
          if (row != ROW_LAST)
            row_d = row + RW'(1);
          else if (WRAP)
            row_d = '0;
        end
        D_LEFT: begin
          if (col != '0)
            col_d = col - CLW'(1);
          else if (WRAP)
            col_d = COL_LAST;
        end
        default: begin
          if (col != COL_LAST)
            col_d = col + CLW'(1);
          else if (WRAP)
            col_d = '0;
        end
      endcase
    end
    // A blocked step leaves the position alone, so it never pulses move.
    move_d = (row_d != row) || (col_d != col);
    cur_bus_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        cur_bus_d[r*COLS + c] = (row_d == RW'(r)) && (col_d == CLW'(c));
      end
    end
  end

endmodule

// File: tb/tb_grid_cursor.sv
// tb_grid_cursor: directed scenarios plus randomized key/enable/reset traffic
// for grid_cursor, checked every cycle against a run-length reference model.

module tb_grid_cursor;

  localparam int ROWS = 6;
  localparam int COLS = 6;
  localparam int HOLD = 4;
  localparam int REP  = 2;

`ifdef GRID_CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        en    = 1'b0;
  logic        up    = 1'b0;
  logic        down  = 1'b0;
  logic        left  = 1'b0;
  logic        right = 1'b0;
  logic [35:0] cur_bus;
  logic [2:0]  row;
  logic [2:0]  col;
  logic        move;

  int total = 0;
  int bad   = 0;

  // Reference model: position plus how many consecutive enabled cycles the
  // current resolved direction has been held.
  int m_row  = 0;
  int m_col  = 0;
  int m_run  = 0;
  int m_dir  = -1;
  bit m_move = 1'b0;

  grid_cursor #(
    .ROWS(ROWS), .COLS(COLS), .HOLD_CYC(HOLD), .REPEAT_CYC(REP),
    .START_ROW(0), .START_COL(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .up(up), .down(down), .left(left), .right(right),
    .cur_bus(cur_bus), .row(row), .col(col), .move(move)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int d;
    bit stp;
    int nr;
    int nc;
    if (!rst) begin
      m_row = 0; m_col = 0; m_run = 0; m_dir = -1; m_move = 1'b0;
      return;
    end
    d = up ? 0 : down ? 1 : left ? 2 : right ? 3 : -1;
    if (!en || d < 0) begin
      m_run = 0; m_move = 1'b0;
      return;
    end
    if (m_run > 0 && d == m_dir) m_run++;
    else m_run = 1;
    m_dir = d;
    // Step on the press itself, after HOLD more cycles, then every REP.
    stp = (m_run == 1) || (m_run > HOLD && ((m_run - 1 - HOLD) % REP) == 0);
    nr = m_row;
    nc = m_col;
    if (stp) begin
      case (d)
        0: nr = m_row - 1;
        1: nr = m_row + 1;
        2: nc = m_col - 1;
        default: nc = m_col + 1;
      endcase
    end
    if (nr < 0)     nr = WRAP ? ROWS - 1 : 0;
    if (nr >= ROWS) nr = WRAP ? 0 : ROWS - 1;
    if (nc < 0)     nc = WRAP ? COLS - 1 : 0;
    if (nc >= COLS) nc = WRAP ? 0 : COLS - 1;
    m_move = (nr != m_row) || (nc != m_col);
    m_row = nr;
    m_col = nc;
  endtask

  task automatic tick();
    logic [35:0] e;
    @(posedge clk);
    model_edge();
    #1;
    e = 36'd1 << (m_row * COLS + m_col);
    chk("row", 64'(row), 64'(m_row));
    chk("col", 64'(col), 64'(m_col));
    chk("cur_bus", 64'(cur_bus), 64'(e));
    chk("move", 64'(move), 64'(m_move));
  endtask

  task automatic set_keys(input logic [3:0] m);
    {up, down, left, right} = m;
  endtask

  task automatic press(input logic [3:0] m);
    set_keys(m);
    tick();
    set_keys(4'b0000);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0] m;
    int n;

    rst = 1'b0;
    en  = 1'b1;
    #1;
    tick();
    tick();
    chk("rst_row", 64'(row), 64'd0);
    chk("rst_col", 64'(col), 64'd0);
    chk("rst_bus", 64'(cur_bus), 64'h1);
    chk("rst_move", 64'(move), 64'd0);
    rst = 1'b1;
    tick();

    // Single right press.
    set_keys(4'b0001);
    tick();
    chk("r1_col", 64'(col), 64'd1);
    chk("r1_bus", 64'(cur_bus), 64'h2);
    chk("r1_move", 64'(move), 64'd1);
    set_keys(4'b0000);
    tick();
    chk("r1_move_off", 64'(move), 64'd0);

    // Hold down from (0,0): steps at cycles 1,5,7,9,11.
    do_reset();
    set_keys(4'b0100);
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("hold_dn_move", 64'(move), 64'((i == 1) || (i == 5) || (i == 7) || (i == 9) || (i == 11)));
    end
    chk("hold_dn_row", 64'(row), 64'd5);
    tick();
    chk("dn_edge_row", 64'(row), WRAP ? 64'd0 : 64'd5);
    chk("dn_edge_move", 64'(move), WRAP ? 64'd1 : 64'd0);
    set_keys(4'b0000);
    tick();

    // up + left together at (3,3): up wins.
    do_reset();
    for (int i = 0; i < 3; i++) press(4'b0100);
    for (int i = 0; i < 3; i++) press(4'b0001);
    set_keys(4'b1010);
    tick();
    chk("prio_row", 64'(row), 64'd2);
    chk("prio_col", 64'(col), 64'd3);
    chk("prio_move", 64'(move), 64'd1);
    set_keys(4'b0000);
    tick();

    // left at (2,0).
    for (int i = 0; i < 3; i++) press(4'b0010);
    chk("at_2_0_col", 64'(col), 64'd0);
    set_keys(4'b0010);
    tick();
    chk("lft_edge_col", 64'(col), WRAP ? 64'd5 : 64'd0);
    chk("lft_edge_bus", 64'(cur_bus), WRAP ? (64'd1 << 17) : (64'd1 << 12));
    chk("lft_edge_move", 64'(move), WRAP ? 64'd1 : 64'd0);
    set_keys(4'b0000);
    tick();

    // en dropped mid-REPEAT.
    do_reset();
    set_keys(4'b0001);
    for (int i = 0; i < 6; i++) tick();
    chk("en_pre_col", 64'(col), 64'd2);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_low_move", 64'(move), 64'd0);
    end
    en = 1'b1;
    tick();
    chk("en_back_move", 64'(move), 64'd1);
    chk("en_back_col", 64'(col), 64'd3);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("en_rehold_move", 64'(move), 64'(i == 4));
    end
    chk("en_rehold_col", 64'(col), 64'd4);
    set_keys(4'b0000);
    tick();

    // Reset during REPEAT with key still held.
    do_reset();
    set_keys(4'b0001);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b0;
    tick();
    chk("rst_rep_row", 64'(row), 64'd0);
    chk("rst_rep_col", 64'(col), 64'd0);
    chk("rst_rep_bus", 64'(cur_bus), 64'h1);
    chk("rst_rep_move", 64'(move), 64'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_col", 64'(col), 64'd1);
    set_keys(4'b0000);
    tick();

    // Random traffic.
    for (int b = 0; b < 300; b++) begin
      m = ($urandom_range(0, 9) < 3) ? 4'b0000 : 4'($urandom_range(0, 15));
      set_keys(m);
      n = $urandom_range(1, 12);
      for (int j = 0; j < n; j++) begin
        en  = ($urandom_range(0, 9) != 0);
        rst = ($urandom_range(0, 199) != 0);
        tick();
      end
    end
    rst = 1'b1;
    en  = 1'b1;
    set_keys(4'b0000);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
